// File: rtl/uart_rx_deserializer.sv
// UART receive deserialiser: oversampled start/data/parity/stop framing with a
// valid/ready holding register carrying parity, framing, break and overrun flags.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  cfgBaudDiv,
    input  logic [4:0]            cfgOverSampling,
    input  logic [3:0]            cfgDataBits,
    input  logic                  cfgParityEnable,
    input  logic                  cfgParityType,
    input  logic [1:0]            cfgStopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  breakError,
    output logic                  overrunError
);

    localparam logic [3:0] MAX_BITS = (DATA_WIDTH < 8) ? 4'(DATA_WIDTH) : 4'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_COMMIT, S_WAIT_HIGH
    } state_t;

    state_t                state;
    logic                  rx_meta, rxs;
    logic [DIV_WIDTH-1:0]  div_cnt, baud_div;
    logic [4:0]            os, ovs;
    logic [3:0]            data_bits, bit_idx;
    logic                  par_en, par_type, two_stop;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit, par_err, frm_err, brk_err;

    logic                  tick, sample, sample_pt, can_load;
    logic [4:0]            os_cfg;
    logic [3:0]            bits_cfg;

    always_comb begin
        tick      = (div_cnt == baud_div);
        os_cfg    = (cfgOverSampling == 5'd13) ? 5'd13 : 5'd16;
        bits_cfg  = cfgDataBits;
        if (cfgDataBits < 4'd5)
            bits_cfg = 4'd5;
        else if (cfgDataBits > MAX_BITS)
            bits_cfg = MAX_BITS;
        // Start bit is judged at mid-bit; all later bits one full bit period apart.
        sample_pt = (state == S_START) ? (ovs == (os >> 1) - 5'd1) : (ovs == os - 5'd1);
        sample    = tick && sample_pt;
        can_load  = !rxValid || rxReady;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            div_cnt      <= '0;
            baud_div     <= '0;
            os           <= 5'd16;
            ovs          <= '0;
            data_bits    <= 4'd8;
            bit_idx      <= '0;
            par_en       <= 1'b0;
            par_type     <= 1'b0;
            two_stop     <= 1'b0;
            shift        <= '0;
            par_bit      <= 1'b0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            brk_err      <= 1'b0;
            rxData       <= '0;
            rxValid      <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            breakError   <= 1'b0;
            overrunError <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick && state != S_IDLE)
                ovs <= sample_pt ? '0 : ovs + 5'd1;

            case (state)
                S_IDLE: begin
                    ovs <= '0;
                    if (!rxs) begin
                        state     <= S_START;
                        div_cnt   <= '0;
                        baud_div  <= cfgBaudDiv;
                        os        <= os_cfg;
                        data_bits <= bits_cfg;
                        par_en    <= cfgParityEnable;
                        par_type  <= cfgParityType;
                        two_stop  <= (cfgStopBits == 2'd2);
                        bit_idx   <= '0;
                        shift     <= '0;
                        par_bit   <= 1'b0;
                        par_err   <= 1'b0;
                        frm_err   <= 1'b0;
                        brk_err   <= 1'b0;
                    end
                end
                S_START:
                    if (sample)
                        state <= rxs ? S_IDLE : S_DATA;
                S_DATA:
                    if (sample) begin
                        shift <= shift | (DATA_WIDTH'(rxs) << bit_idx);
                        if (bit_idx == data_bits - 4'd1)
                            state <= par_en ? S_PARITY : S_STOP1;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end
                S_PARITY:
                    if (sample) begin
                        par_bit <= rxs;
                        par_err <= ((^shift) ^ rxs) != par_type;
                        state   <= S_STOP1;
                    end
                S_STOP1:
                    if (sample) begin
                        frm_err <= !rxs;
                        brk_err <= (shift == '0) && !par_bit && !rxs;
                        state   <= two_stop ? S_STOP2 : S_COMMIT;
                    end
                S_STOP2:
                    if (sample) begin
                        frm_err <= frm_err | !rxs;
                        state   <= S_COMMIT;
                    end
                S_COMMIT:
                    state <= rxs ? S_IDLE : S_WAIT_HIGH;
                S_WAIT_HIGH:
                    if (rxs)
                        state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase

            if (state == S_COMMIT) begin
                if (can_load) begin
                    rxData       <= shift;
                    rxValid      <= 1'b1;
                    parityError  <= par_err;
                    framingError <= frm_err | brk_err;
                    breakError   <= brk_err;
                    overrunError <= 1'b0;
                end else begin
                    overrunError <= 1'b1;
                end
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: serial frames are driven on rx,
// expected characters/flags queued per frame and compared when rxValid appears.
module tb_uart_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] cfg_div;
    logic [4:0]  cfg_os;
    logic [3:0]  cfg_bits;
    logic        cfg_pen;
    logic        cfg_ptype;
    logic [1:0]  cfg_stop;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        parityError, framingError, breakError, overrunError;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_deserializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .cfgBaudDiv(cfg_div), .cfgOverSampling(cfg_os), .cfgDataBits(cfg_bits),
        .cfgParityEnable(cfg_pen), .cfgParityType(cfg_ptype), .cfgStopBits(cfg_stop),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .parityError(parityError), .framingError(framingError),
        .breakError(breakError), .overrunError(overrunError)
    );

    function automatic int bit_period();
        return int'(cfg_os) * (int'(cfg_div) + 1);
    endfunction

    function automatic logic [7:0] data_mask();
        return 8'hFF >> (4'd8 - cfg_bits);
    endfunction

    // Expected {data, parity, framing, break, overrun} for a frame.
    function automatic logic [11:0] make_exp(logic [7:0] d, bit flip, logic s1, logic s2, logic ovr);
        logic [7:0] m;
        logic p, frm, brk;
        m   = d & data_mask();
        p   = (^m) ^ cfg_ptype ^ flip;
        brk = (m == 8'h00) && (!cfg_pen || !p) && !s1;
        frm = !s1 || (cfg_stop == 2'd2 && !s2) || brk;
        return {m, cfg_pen & flip, frm, brk, ovr};
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_period()) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input logic s1, input logic s2);
        logic [7:0] m;
        m = d & data_mask();
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < int'(cfg_bits); i++) drive_bit(m[i]);
        if (cfg_pen) drive_bit((^m) ^ cfg_ptype ^ flip);
        drive_bit(s1);
        if (cfg_stop == 2'd2) drive_bit(s2);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rxValid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        @(posedge clk); #1 rxReady = 1'b1;
        @(posedge clk); #1 rxReady = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] dv, input logic [4:0] os, input logic [3:0] nb,
                           input logic pen, input logic pt, input logic [1:0] st);
        cfg_div = dv; cfg_os = os; cfg_bits = nb; cfg_pen = pen; cfg_ptype = pt; cfg_stop = st;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx = 1'b1; rxReady = 1'b0;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rxValid, rxData, parityError, framingError, breakError, overrunError} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {rxValid, rxData, parityError, framingError, breakError, overrunError});
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int lat;
        bit ok;
        logic [11:0] e;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        exp_q.push_back(make_exp(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0));
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); lat++;
                    @(negedge clk);
                    if (rxValid) break;
                end
            end
        join
        checks++;
        if (lat < 155 || lat > 157) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles expected 156 (+/-1)", lat);
        end
        wait_valid(50, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL basic_A5: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
        @(negedge clk);
        checks++;
        if (rxValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_drop: got rxValid=%b expected 0", rxValid);
        end
    endtask

    task automatic test_parity();
        bit ok;
        logic [11:0] e;
        set_cfg(16'd3, 5'd13, 4'd7, 1'b1, 1'b1, 2'd1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(make_exp(8'h41, k[0], 1'b1, 1'b1, 1'b0));
            send_frame(8'h41, k[0], 1'b1, 1'b1);
            wait_valid(200, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
                errors++;
                $display("FAIL parity_%0d: got valid=%b %h expected %h", k, rxValid,
                         {rxData, parityError, framingError, breakError, overrunError}, e);
            end
            accept();
        end
    endtask

    task automatic test_framing_break();
        bit ok, seen;
        logic [11:0] e;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd2);
        exp_q.push_back(make_exp(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL framing_stop2: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();

        exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1 rx = 1'b0;
        repeat (12 * bit_period()) @(posedge clk);
        #1;
        wait_valid(50, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL break_frame: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
        seen = 1'b0;
        for (int i = 0; i < 14 * bit_period(); i++) begin
            @(negedge clk);
            if (rxValid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL break_wait_high: got a frame while rx low, expected none");
        end
        @(posedge clk); #1 rx = 1'b1;
        repeat (2 * bit_period()) @(posedge clk);
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        exp_q.push_back(make_exp(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0));
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL break_recover: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
    endtask

    task automatic test_overrun();
        bit ok;
        logic [11:0] e;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        exp_q.push_back(make_exp(8'h11, 1'b0, 1'b1, 1'b1, 1'b1));
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL overrun_keep_old: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
        @(negedge clk);
        checks++;
        if (rxValid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_valid_drop: got rxValid=%b expected 0", rxValid);
        end
        exp_q.push_back(make_exp(8'h33, 1'b0, 1'b1, 1'b1, 1'b0));
        send_frame(8'h33, 1'b0, 1'b1, 1'b1);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL overrun_third_clean: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
    endtask

    task automatic test_glitch_reset();
        bit ok, seen;
        logic [11:0] e;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 * bit_period(); i++) begin
            @(negedge clk);
            if (rxValid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL glitch_no_frame: got a frame expected none");
        end

        exp_q.push_back(make_exp(8'h77, 1'b0, 1'b1, 1'b1, 1'b0));
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL pre_reset_77: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        // 0x5A partially sent (start + 3 data bits), then reset mid-DATA.
        @(posedge clk); #1;
        drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rxValid, rxData, parityError, framingError, breakError, overrunError} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h expected 0",
                     {rxValid, rxData, parityError, framingError, breakError, overrunError});
        end
        @(posedge clk); #1 rx = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk);

        exp_q.push_back(make_exp(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0));
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rxData, parityError, framingError, breakError, overrunError} !== e) begin
            errors++;
            $display("FAIL post_reset_C3: got valid=%b %h expected %h", rxValid,
                     {rxData, parityError, framingError, breakError, overrunError}, e);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int got;
        logic [11:0] e;
        set_cfg(16'd0, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        @(posedge clk); #1 rxReady = 1'b1;
        exp_q.push_back(make_exp(8'h01, 1'b0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(make_exp(8'h02, 1'b0, 1'b1, 1'b1, 1'b0));
        got = 0;
        fork
            begin
                send_frame(8'h01, 1'b0, 1'b1, 1'b1);
                send_frame(8'h02, 1'b0, 1'b1, 1'b1);
            end
            for (int i = 0; i < 600 && got < 2; i++) begin
                @(negedge clk);
                if (rxValid) begin
                    got++;
                    e = exp_q.pop_front();
                    checks++;
                    if ({rxData, parityError, framingError, breakError, overrunError} !== e) begin
                        errors++;
                        $display("FAIL b2b_char%0d: got %h expected %h", got,
                                 {rxData, parityError, framingError, breakError, overrunError}, e);
                    end
                end
            end
        join
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d characters expected 2", got);
        end
        exp_q.delete();
        @(posedge clk); #1 rxReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing_break();
        test_overrun();
        test_glitch_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
